// File: rtl/vfb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vfb_arb_pkg
//  Purpose  : Shared types and requester index helpers for frame-buffer arbiters
//  Revision : 1.0  initial release
// ============================================================================
package vfb_arb_pkg;

    localparam int NUM_CH_MAX = 4;
    localparam int NREQ       = 2 * NUM_CH_MAX;
    localparam int IDX_W      = $clog2(NREQ);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Requester 2k is channel k's write DMA, 2k+1 its read DMA.
    function automatic logic is_read(input logic [IDX_W-1:0] idx);
        return idx[0];
    endfunction

    function automatic logic [IDX_W-2:0] channel_of(input logic [IDX_W-1:0] idx);
        return idx[IDX_W-1:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_pick
//  Purpose  : First-set request search starting at a pointer, with fixed bypass
//  Revision : 1.0  initial release
// ============================================================================
module rr_priority_pick #(
    parameter int N             = 8,
    parameter int W             = 3,
    parameter int PRIORITY_MODE = 0
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [W-1:0] w_start;

    generate
        if (PRIORITY_MODE != 0) begin : g_fixed
            logic w_unused_ptr;
            assign w_unused_ptr = ^ptr;
            assign w_start      = '0;
        end else begin : g_rr
            assign w_start = ptr;
        end
    endgenerate

    always_comb begin
        int pos;
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(w_start) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!valid && req[pos]) begin
                valid = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_bus_arbiter_mc.sv
`default_nettype none
// ============================================================================
//  Module   : dma_bus_arbiter_mc
//  Purpose  : Per-burst arbiter muxing NUM_CH read/write DMAs onto one DDR port
//  Revision : 1.0  initial release
// ============================================================================
module dma_bus_arbiter_mc
    import vfb_arb_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int ADDR_WIDTH       = 26,
    parameter int DATA_WIDTH       = 64,
    parameter int MASK_WIDTH       = 8,
    parameter int PRIORITY_MODE    = 0,
    parameter int MAX_GRANT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           init_done,
    input  logic [2*NUM_CH-1:0]            req_i,
    input  logic [2*NUM_CH-1:0]            end_i,
    output logic [2*NUM_CH-1:0]            grant_o,
    input  logic [2*NUM_CH-1:0]            cmd_i,
    input  logic [2*NUM_CH-1:0]            cmd_en_i,
    input  logic [2*NUM_CH*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   wr_data_i,
    input  logic [NUM_CH*MASK_WIDTH-1:0]   data_mask_i,
    output logic                           cmd,
    output logic                           cmd_en,
    output logic [ADDR_WIDTH-1:0]          addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic [MASK_WIDTH-1:0]          data_mask,
    input  logic                           rd_data_valid,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_CH-1:0]              rd_valid_o,
    output logic [NUM_CH*DATA_WIDTH-1:0]   rd_data_o,
    output logic                           timeout_o,
    output logic                           stray_rd_o
);

    localparam int c_nreq = 2 * NUM_CH;
    localparam int c_ch_w = IDX_W - 1;
    localparam int c_wd_w = (MAX_GRANT_CYCLES > 1) ? $clog2(MAX_GRANT_CYCLES) : 1;
    localparam logic [c_wd_w-1:0] c_wd_last =
        c_wd_w'((MAX_GRANT_CYCLES > 0) ? MAX_GRANT_CYCLES - 1 : 0);

    arb_state_t                 r_state;
    logic [IDX_W-1:0]           r_owner;
    logic [IDX_W-1:0]           r_ptr;
    logic [c_wd_w-1:0]          r_wd_cnt;
    logic [c_nreq-1:0]          r_grant;
    logic                       r_cmd;
    logic                       r_cmd_en;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [DATA_WIDTH-1:0]      r_wr_data;
    logic [MASK_WIDTH-1:0]      r_mask;
    logic [NUM_CH-1:0]          r_rd_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] r_rd_data;
    logic                       r_timeout;
    logic                       r_stray;

    logic                       w_pick_valid;
    logic [IDX_W-1:0]           w_pick_idx;
    logic [IDX_W-1:0]           w_ptr_next;
    logic [c_ch_w-1:0]          w_own_ch;
    logic                       w_own_cmd;
    logic                       w_own_cmd_en;
    logic                       w_own_end;
    logic [ADDR_WIDTH-1:0]      w_own_addr;
    logic [DATA_WIDTH-1:0]      w_own_wr_data;
    logic [MASK_WIDTH-1:0]      w_own_mask;
    logic                       w_wd_expired;

    rr_priority_pick #(
        .N             (c_nreq),
        .W             (IDX_W),
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_pick (
        .req   (req_i),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_ptr_next   = (w_pick_idx == IDX_W'(c_nreq - 1)) ? '0 : w_pick_idx + IDX_W'(1);
    assign w_own_ch     = channel_of(r_owner);
    assign w_wd_expired = (MAX_GRANT_CYCLES != 0) && (r_wd_cnt == c_wd_last);

    always_comb begin
        w_own_cmd     = 1'b0;
        w_own_cmd_en  = 1'b0;
        w_own_end     = 1'b0;
        w_own_addr    = '0;
        w_own_wr_data = '0;
        w_own_mask    = '0;
        for (int i = 0; i < c_nreq; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_cmd    = cmd_i[i];
                w_own_cmd_en = cmd_en_i[i];
                w_own_end    = end_i[i];
                w_own_addr   = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_own_ch == c_ch_w'(k)) begin
                w_own_wr_data = wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                w_own_mask    = data_mask_i[k*MASK_WIDTH +: MASK_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_wd_cnt   <= '0;
            r_grant    <= '0;
            r_cmd      <= 1'b0;
            r_cmd_en   <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_mask     <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_timeout  <= 1'b0;
            r_stray    <= 1'b0;
        end else begin
            r_cmd     <= w_own_cmd;
            r_cmd_en  <= (r_state == ST_GRANT) && w_own_cmd_en;
            r_addr    <= w_own_addr;
            r_wr_data <= w_own_wr_data;
            r_mask    <= w_own_mask;

            // A read beat only belongs to a channel whose read DMA owns the port.
            r_rd_valid <= '0;
            if (rd_data_valid) begin
                if ((r_state == ST_GRANT) && is_read(r_owner)) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (w_own_ch == c_ch_w'(k)) begin
                            r_rd_valid[k]                         <= 1'b1;
                            r_rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
                        end
                    end
                end else begin
                    r_stray <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (init_done && w_pick_valid) begin
                        r_state  <= ST_GRANT;
                        r_owner  <= w_pick_idx;
                        r_grant  <= c_nreq'(1) << w_pick_idx;
                        r_wd_cnt <= '0;
                        if (PRIORITY_MODE == 0) begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                end
                ST_GRANT: begin
                    if (w_own_end) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end else if (w_wd_expired) begin
                        r_state   <= ST_IDLE;
                        r_grant   <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
                    end
                end
            endcase
        end
    end

    assign grant_o    = r_grant;
    assign cmd        = r_cmd;
    assign cmd_en     = r_cmd_en;
    assign addr       = r_addr;
    assign wr_data    = r_wr_data;
    assign data_mask  = r_mask;
    assign rd_valid_o = r_rd_valid;
    assign rd_data_o  = r_rd_data;
    assign timeout_o  = r_timeout;
    assign stray_rd_o = r_stray;

endmodule
`default_nettype wire
